fetch_unit: RTL and testbench

Instruction fetch front end for the rv32i core. It produces the instruction word consumed by the decode stage.
- Owns the PC.
- Issues read requests to instruction memory over a valid/ready request channel plus a response channel.
- Buffers returned words with their PC in a small FIFO.
- Hands words to decode over a valid/ready interface.
- Branch/jump redirects from execute flush buffered and in-flight fetches.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i front end.
// Holds instruction/PC widths, reset PC, the NOP encoding and the fetch entry type.
package rv32i_pkg;

    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // One buffered fetch result: the word and the PC it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc;
    } if_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a registered head.
// Ports: push/push_data write, pop read, flush clears (wins over push),
// full/empty/count status, head is the oldest entry (0 after reset).
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  if_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output if_entry_t     head
);

    if_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: owns the PC, issues credit-limited memory reads,
// buffers returned words with their PC and hands them to decode.
// Ports: clk/rst; o_im_ar* request channel; i_im_r*/o_im_rready response channel;
// i_redirect_* flush+retarget from execute; o_if_*/i_if_ready decode handshake.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] o_im_araddr,
    output logic            o_im_arvalid,
    input  logic            i_im_arready,
    input  logic            i_im_rvalid,
    input  logic [XLEN-1:0] i_im_rdata,
    output logic            o_im_rready,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_instr,
    output logic [XLEN-1:0] o_if_pc,
    input  logic            i_if_ready
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_n;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] resp_pc_n;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] redir_pc_n;
    logic            redir_pend;
    logic            redir_pend_n;
    logic            arvalid;
    logic            arvalid_n;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_n;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_cnt_n;

    logic            req_hs;
    logic            req_hold;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   count_n;
    logic [CW:0]     credit;

    if_entry_t       push_data;
    if_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign req_hs   = arvalid & i_im_arready;
    assign req_hold = arvalid & ~i_im_arready;
    assign target   = i_redirect_pc & PC_MASK;

    // Words owed to an older stream, or arriving with a redirect, are dropped.
    assign push = i_im_rvalid & (drop_cnt == '0) & ~i_redirect_valid;
    assign pop  = ~fifo_empty & i_if_ready;

    assign push_data = '{instr: i_im_rdata, pc: resp_pc};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (i_redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    always_comb begin
        outstanding_n = outstanding + CW'(req_hs) - CW'(i_im_rvalid);
        drop_cnt_n    = drop_cnt;
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        redir_pc_n    = redir_pc;
        redir_pend_n  = redir_pend;

        if (i_im_rvalid && drop_cnt != '0) begin
            drop_cnt_n = drop_cnt - CW'(1);
        end

        // A redirect seen while a request was stalled is applied once it is accepted.
        if (req_hs) begin
            fetch_pc_n   = redir_pend ? redir_pc : fetch_pc + PC_STEP;
            redir_pend_n = 1'b0;
        end

        if (push) begin
            resp_pc_n = resp_pc + PC_STEP;
        end

        if (i_redirect_valid) begin
            resp_pc_n  = target;
            // A stalled request still completes later, so it is owed a drop too.
            drop_cnt_n = outstanding_n + CW'(req_hold);
            if (req_hold) begin
                redir_pend_n = 1'b1;
                redir_pc_n   = target;
            end else begin
                fetch_pc_n   = target;
                redir_pend_n = 1'b0;
            end
        end

        count_n = i_redirect_valid ? '0
                : fifo_count + CW'(push) - CW'(pop);

        // Credit check on next-cycle occupancy guarantees every response a slot.
        credit    = (CW + 1)'(count_n) + (CW + 1)'(outstanding_n);
        arvalid_n = req_hold | (credit < (CW + 1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            redir_pc    <= RESET_PC;
            redir_pend  <= 1'b0;
            arvalid     <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            redir_pc    <= redir_pc_n;
            redir_pend  <= redir_pend_n;
            arvalid     <= arvalid_n;
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
        end
    end

    // A response with nothing outstanding, or a push into a full FIFO,
    // means the memory broke the one-response-per-request contract.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_im_rvalid && outstanding == '0));
            assert (!(push && fifo_full && !pop));
        end
    end

    assign o_im_araddr  = fetch_pc;
    assign o_im_arvalid = arvalid;
    assign o_im_rready  = 1'b1;
    assign o_if_valid   = ~fifo_empty;
    assign o_if_instr   = head.instr;
    assign o_if_pc      = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers with addr+0x100,
// a monitor checks every word decode consumes against a queue of expected entries.
module tb_fetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] o_im_araddr;
    logic        o_im_arvalid;
    logic        i_im_arready = 1'b0;
    logic        i_im_rvalid = 1'b0;
    logic [31:0] i_im_rdata = '0;
    logic        o_im_rready;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic        i_if_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        rq[$];
    logic [31:0] acc_log[$];
    if_entry_t   exp_q[$];
    int          cyc = 0;
    int          lat = 1;
    logic        ar_en = 1'b0;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RPC),
        .DEPTH    (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .o_im_araddr      (o_im_araddr),
        .o_im_arvalid     (o_im_arvalid),
        .i_im_arready     (i_im_arready),
        .i_im_rvalid      (i_im_rvalid),
        .i_im_rdata       (i_im_rdata),
        .o_im_rready      (o_im_rready),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_if_valid       (o_if_valid),
        .o_if_instr       (o_if_instr),
        .o_if_pc          (o_if_pc),
        .i_if_ready       (i_if_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: in-order responses, lat cycles after the handshake.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            rq.delete();
            i_im_rvalid  = 1'b0;
            i_im_rdata   = '0;
            i_im_arready = 1'b0;
        end else begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                i_im_rvalid = 1'b1;
                i_im_rdata  = rq[0].addr + 32'h100;
                void'(rq.pop_front());
            end else begin
                i_im_rvalid = 1'b0;
                i_im_rdata  = '0;
            end
            i_im_arready = ar_en;
            if (o_im_arvalid && i_im_arready) begin
                rq.push_back('{addr: o_im_araddr, due: cyc + lat});
                acc_log.push_back(o_im_araddr);
            end
        end
    end

    // Monitor: every word taken by decode must match the scoreboard head.
    always begin
        if_entry_t e;
        @(negedge clk);
        #2;
        if (!rst && !i_redirect_valid && o_if_valid && i_if_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got pc=%h instr=%h expected none",
                         o_if_pc, o_if_instr);
            end else begin
                e = exp_q.pop_front();
                check("decode", {o_if_instr, o_if_pc}, {e.instr, e.pc});
            end
        end
    end

    task automatic push_stream(input logic [31:0] pc, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc + 32'(i * 4);
            exp_q.push_back('{instr: p + 32'h100, pc: p});
        end
    endtask

    task automatic drain();
        i_if_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words left expected 0",
                     exp_q.size());
        end
        i_if_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset(input logic ar);
        @(negedge clk);
        rst              = 1'b1;
        i_if_ready       = 1'b0;
        i_redirect_valid = 1'b0;
        ar_en            = ar;
        lat              = 1;
        exp_q.delete();
        acc_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_arvalid", 64'(o_im_arvalid), 64'd0);
        check("rst_ifvalid", 64'(o_if_valid), 64'd0);
        check("rst_araddr", 64'(o_im_araddr), 64'(RPC));
        check("rst_instr", 64'(o_if_instr), 64'd0);
        check("rst_pc", 64'(o_if_pc), 64'd0);
        check("rst_rready", 64'(o_im_rready), 64'd1);

        // Streaming fetch
        ar_en = 1'b1;
        lat   = 1;
        push_stream(32'h0, 8);
        rst = 1'b0;
        drain();
        check("stream_req0", 64'(acc_log[0]), 64'h0);
        check("stream_req1", 64'(acc_log[1]), 64'h4);
        check("stream_req2", 64'(acc_log[2]), 64'h8);

        // Decode back-pressure: credits cap requests at DEPTH
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        check("bp_nreq", 64'(acc_log.size()), 64'd2);
        check("bp_arvalid", 64'(o_im_arvalid), 64'd0);
        push_stream(32'h0, 4);
        drain();
        check("bp_resume", 64'(acc_log[2]), 64'h8);

        // arready stall keeps the request stable
        do_reset(1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_arvalid", 64'(o_im_arvalid), 64'd1);
            check("stall_araddr", 64'(o_im_araddr), 64'h0);
        end
        ar_en = 1'b1;
        @(negedge clk);
        check("stall_next", 64'(o_im_araddr), 64'h4);
        push_stream(32'h0, 3);
        drain();

        // Redirect with two requests in flight
        do_reset(1'b1);
        lat = 4;
        repeat (3) @(negedge clk);
        check("rd2_arvalid", 64'(o_im_arvalid), 64'd0);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h200;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        lat = 1;
        check("rd2_ifvalid", 64'(o_if_valid), 64'd0);
        push_stream(32'h200, 4);
        drain();
        check("rd2_req", 64'(acc_log[2]), 64'h200);

        // Redirect coincident with response and pop
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        check("rdc_ifvalid_pre", 64'(o_if_valid), 64'd1);
        i_if_ready       = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h303;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        i_if_ready       = 1'b0;
        check("rdc_ifvalid", 64'(o_if_valid), 64'd0);
        push_stream(32'h300, 3);
        drain();
        check("rdc_req", 64'(acc_log[2]), 64'h300);

        // Reset mid-operation with a word buffered and one in flight
        do_reset(1'b1);
        lat = 3;
        repeat (5) @(negedge clk);
        check("mr_ifvalid_pre", 64'(o_if_valid), 64'd1);
        rst = 1'b1;
        acc_log.delete();
        @(negedge clk);
        check("mr_ifvalid", 64'(o_if_valid), 64'd0);
        check("mr_arvalid", 64'(o_im_arvalid), 64'd0);
        check("mr_araddr", 64'(o_im_araddr), 64'(RPC));
        rst = 1'b0;
        lat = 1;
        push_stream(32'h0, 3);
        drain();
        check("mr_req0", 64'(acc_log[0]), 64'(RPC));
        check("mr_req1", 64'(acc_log[1]), 64'h4);

        // Redirect to the top of the address space, PC wraps to 0
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        check("wrap_ifvalid", 64'(o_if_valid), 64'd0);
        push_stream(32'hFFFF_FFFC, 3);
        drain();

        // Redirect while a request is stalled: it is dropped, PC reloads after
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h400;
        @(negedge clk);
        i_redirect_valid = 1'b0;
        check("pend_araddr", 64'(o_im_araddr), 64'h0);
        check("pend_arvalid", 64'(o_im_arvalid), 64'd1);
        ar_en = 1'b1;
        @(negedge clk);
        check("pend_reload", 64'(o_im_araddr), 64'h400);
        push_stream(32'h400, 3);
        drain();
        check("pend_req0", 64'(acc_log[0]), 64'h0);
        check("pend_req1", 64'(acc_log[1]), 64'h400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
